// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and helpers for the PS/2 key tracker.
// Build option: define PS2_EXTENDED_KEYS_EN to enable E0-prefixed (extended) key tracking.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BAT   = 8'hAA;
    localparam logic [7:0] PS2_OVR0  = 8'h00;
    localparam logic [7:0] PS2_OVR1  = 8'hFF;

`ifdef PS2_EXTENDED_KEYS_EN
    localparam bit EXT_KEYS_EN = 1'b1;
`else
    localparam bit EXT_KEYS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_trk_state_t;

    // BAT completion and both overrun codes force a keyboard-wide release.
    function automatic logic is_release_all(input logic [7:0] c);
        return (c == PS2_BAT) || (c == PS2_OVR0) || (c == PS2_OVR1);
    endfunction

endpackage

// File: rtl/ps2_key_lookup.sv
// Combinational scan-code matcher: one-hot hit vector over the configured key table.
// With PS2_EXTENDED_KEYS_EN undefined, KEY_EXT is ignored and every key matches in plain context.
module ps2_key_lookup
    import ps2_pkg::*;
#(
    parameter int                       NUM_KEYS  = 9,
    parameter logic [NUM_KEYS*8-1:0]    KEY_CODES = {8'h1C, 8'h2C, 8'h15, 8'h1B, 8'h2D,
                                                     8'h2B, 8'h24, 8'h23, 8'h1D},
    parameter logic [NUM_KEYS-1:0]      KEY_EXT   = '0
) (
    input  logic [7:0]          code,
    input  logic                ext,
    output logic [NUM_KEYS-1:0] hit
);

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if ((KEY_CODES[8*i +: 8] == code) && (!EXT_KEYS_EN || (KEY_EXT[i] == ext))) begin
                hit[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 key tracker: prefix FSM, per-key held state, one-cycle make/break pulses.
// Build option: PS2_EXTENDED_KEYS_EN enables the E0 prefix states and KEY_EXT matching.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int                       NUM_KEYS  = 9,
    parameter logic [NUM_KEYS*8-1:0]    KEY_CODES = {8'h1C, 8'h2C, 8'h15, 8'h1B, 8'h2D,
                                                     8'h2B, 8'h24, 8'h23, 8'h1D},
    parameter logic [NUM_KEYS-1:0]      KEY_EXT   = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                code_valid,
    input  logic [7:0]          code,
    input  logic                par_err,
    output logic [NUM_KEYS-1:0] key_make,
    output logic [NUM_KEYS-1:0] key_break,
    output logic [NUM_KEYS-1:0] key_held,
    output logic                any_held,
    output logic                err_seen,
    output logic [1:0]          state_dbg
);

    ps2_trk_state_t      state_q, state_d;
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic [NUM_KEYS-1:0] make_q, make_d;
    logic [NUM_KEYS-1:0] break_q, break_d;
    logic                any_q, any_d;
    logic                err_q, err_d;
    logic                ext_ctx;
    logic [NUM_KEYS-1:0] hit;

    assign ext_ctx = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);

    ps2_key_lookup #(
        .NUM_KEYS  (NUM_KEYS),
        .KEY_CODES (KEY_CODES),
        .KEY_EXT   (KEY_EXT)
    ) u_lookup (
        .code (code),
        .ext  (ext_ctx),
        .hit  (hit)
    );

    // Input is a single-cycle strobe; nothing changes and no pulse fires without it.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        make_d  = '0;
        break_d = '0;
        err_d   = err_q;
        if (code_valid) begin
            if (par_err) begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end else if (is_release_all(code)) begin
                break_d = held_q;
                held_d  = '0;
                state_d = ST_IDLE;
            end else if (!(code == PS2_EXT && !EXT_KEYS_EN)) begin
                case (state_q)
                    ST_IDLE: begin
                        if (code == PS2_BREAK) begin
                            state_d = ST_BRK;
                        end else if (code == PS2_EXT) begin
                            state_d = ST_EXT;
                        end else begin
                            make_d = hit & ~held_q;
                            held_d = held_q | hit;
                        end
                    end
                    ST_EXT: begin
                        if (code == PS2_BREAK) begin
                            state_d = ST_EXT_BRK;
                        end else begin
                            make_d  = hit & ~held_q;
                            held_d  = held_q | hit;
                            state_d = ST_IDLE;
                        end
                    end
                    ST_BRK, ST_EXT_BRK: begin
                        // A second F0 is swallowed as a miss rather than re-arming the break.
                        if (code != PS2_BREAK) begin
                            break_d = hit & held_q;
                            held_d  = held_q & ~hit;
                        end
                        state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
        any_d = |held_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            held_q  <= '0;
            make_q  <= '0;
            break_q <= '0;
            any_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            make_q  <= make_d;
            break_q <= break_d;
            any_q   <= any_d;
            err_q   <= err_d;
        end
    end

    assign key_make  = make_q;
    assign key_break = break_q;
    assign key_held  = held_q;
    assign any_held  = any_q;
    assign err_seen  = err_q;
    assign state_dbg = state_q;

endmodule
